// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan capture: segment codes,
// the blank pattern, FSM states and select-decoding helpers.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    // Active-low {g,f,e,d,c,b,a} codes, indexed by the hex value they show.
    localparam logic [6:0] SEG_CODES [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    // A select is legal only when exactly one active-low anode is driven.
    function automatic logic an_legal(input logic [3:0] an);
        return ($countones(~an) == 1);
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational lookup of a 7-bit active-low segment pattern into a hex
// nibble, with flags for a recognised code and for the all-off pattern.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic       o_match,
    output logic       o_blank,
    output logic [3:0] o_nibble
);

    always_comb begin
        o_match  = 1'b0;
        o_blank  = (i_pattern == SEG_BLANK);
        o_nibble = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i_pattern == SEG_CODES[i]) begin
                o_match  = 1'b1;
                o_nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Recovers the four hex digits driven onto a multiplexed seven-segment
// display by sampling each digit once its anode and segment lines settle.
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int unsigned SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  AN,
    input  logic [7:0]  SEGMENT,
    output logic [15:0] hex,
    output logic [3:0]  points,
    output logic [3:0]  blank,
    output logic [3:0]  err,
    output logic        frame
);

    localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

    logic [3:0]  r_an;
    logic [7:0]  r_seg;
    logic [3:0]  r_an_p;
    logic [7:0]  r_seg_p;
    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [15:0] r_hex;
    logic [3:0]  r_pts;
    logic [3:0]  r_blank;
    logic [3:0]  r_err;
    logic [3:0]  r_mask;
    logic        r_frame;

    logic        w_changed;
    logic        w_legal;
    logic [1:0]  w_idx;
    logic [3:0]  w_sel;
    logic [3:0]  w_mask_next;
    logic        w_match;
    logic        w_blank;
    logic [3:0]  w_nibble;

    assign w_changed   = (r_an != r_an_p) || (r_seg != r_seg_p);
    assign w_legal     = an_legal(r_an);
    assign w_idx       = an_index(r_an);
    assign w_sel       = 4'b0001 << w_idx;
    assign w_mask_next = r_mask | w_sel;

    seg_pattern_decode u_decode (
        .i_pattern (r_seg[6:0]),
        .o_match   (w_match),
        .o_blank   (w_blank),
        .o_nibble  (w_nibble)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an    <= '1;
            r_seg   <= '1;
            r_an_p  <= '1;
            r_seg_p <= '1;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hex   <= '0;
            r_pts   <= '0;
            r_blank <= '0;
            r_err   <= '0;
            r_mask  <= '0;
            r_frame <= 1'b0;
        end else begin
            r_an    <= AN;
            r_seg   <= SEGMENT;
            r_an_p  <= r_an;
            r_seg_p <= r_seg;
            r_frame <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_legal) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= 8'd1;
                    end else begin
                        r_cnt   <= '0;
                    end
                end

                ST_SETTLE, ST_HELD: begin
                    if (w_changed) begin
                        if (w_legal) begin
                            r_state <= ST_SETTLE;
                            r_cnt   <= 8'd1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end
                    end else if (r_state == ST_SETTLE) begin
                        if (r_cnt + 8'd1 == SETTLE_CNT) begin
                            // Stable long enough: take the sample on this edge.
                            r_state <= ST_HELD;
                            r_cnt   <= SETTLE_CNT;
                            r_pts[w_idx]   <= ~r_seg[7];
                            r_blank[w_idx] <= ~w_match & w_blank;
                            r_err[w_idx]   <= ~w_match & ~w_blank;
                            if (w_match) r_hex[{w_idx, 2'b00} +: 4] <= w_nibble;
                            if (w_mask_next == 4'hF) begin
                                r_mask  <= '0;
                                r_frame <= 1'b1;
                            end else begin
                                r_mask  <= w_mask_next;
                            end
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign hex    = r_hex;
    assign points = r_pts;
    assign blank  = r_blank;
    assign err    = r_err;
    assign frame  = r_frame;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: each applied digit pushes the
// predicted outputs, which are popped and compared once the hold time ends.
module tb_seg_scan_capture;

    localparam int unsigned SETTLE = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  AN;
    logic [7:0]  SEGMENT;
    logic [15:0] hex;
    logic [3:0]  points;
    logic [3:0]  blank;
    logic [3:0]  err;
    logic        frame;

    int n_checks = 0;
    int n_fail   = 0;
    int frame_cnt = 0;

    typedef struct {
        string       tag;
        logic [15:0] hex;
        logic [3:0]  pts;
        logic [3:0]  blank;
        logic [3:0]  err;
        int          frames;
    } exp_t;

    exp_t sb[$];

    logic [15:0] m_hex;
    logic [3:0]  m_pts, m_blank, m_err, m_mask;
    int          m_frames;

    seg_scan_capture #(.SETTLE(SETTLE)) dut (
        .clk     (clk),
        .rst     (rst),
        .AN      (AN),
        .SEGMENT (SEGMENT),
        .hex     (hex),
        .points  (points),
        .blank   (blank),
        .err     (err),
        .frame   (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (frame) frame_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_decode(input logic [6:0] c, output logic ok, output logic [3:0] v);
        ok = 1'b1;
        v  = 4'h0;
        case (c)
            7'h40: v = 4'h0;  7'h79: v = 4'h1;  7'h24: v = 4'h2;  7'h30: v = 4'h3;
            7'h19: v = 4'h4;  7'h12: v = 4'h5;  7'h02: v = 4'h6;  7'h78: v = 4'h7;
            7'h00: v = 4'h8;  7'h10: v = 4'h9;  7'h08: v = 4'hA;  7'h03: v = 4'hB;
            7'h46: v = 4'hC;  7'h21: v = 4'hD;  7'h06: v = 4'hE;  7'h0E: v = 4'hF;
            default: ok = 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_hex = '0; m_pts = '0; m_blank = '0; m_err = '0; m_mask = '0;
    endtask

    task automatic model_sample(input logic [3:0] an, input logic [7:0] seg);
        int          idx;
        logic        ok;
        logic [3:0]  v;
        idx = 0;
        for (int i = 0; i < 4; i++) if (!an[i]) idx = i;
        ref_decode(seg[6:0], ok, v);
        m_pts[idx]   = ~seg[7];
        m_blank[idx] = !ok && (seg[6:0] == 7'h7F);
        m_err[idx]   = !ok && (seg[6:0] != 7'h7F);
        if (ok) m_hex[idx*4 +: 4] = v;
        m_mask[idx] = 1'b1;
        if (m_mask == 4'hF) begin
            m_frames++;
            m_mask = '0;
        end
    endtask

    task automatic apply(input logic [3:0] an, input logic [7:0] seg, input int n,
                         input bit smp, input string tag);
        exp_t e;
        AN = an;
        SEGMENT = seg;
        if (smp) model_sample(an, seg);
        e.tag = tag; e.hex = m_hex; e.pts = m_pts; e.blank = m_blank;
        e.err = m_err; e.frames = m_frames;
        sb.push_back(e);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
        e = sb.pop_front();
        check_eq({e.tag, ".hex"},    32'(hex),       32'(e.hex));
        check_eq({e.tag, ".points"}, 32'(points),    32'(e.pts));
        check_eq({e.tag, ".blank"},  32'(blank),     32'(e.blank));
        check_eq({e.tag, ".err"},    32'(err),       32'(e.err));
        check_eq({e.tag, ".frames"}, 32'(frame_cnt), 32'(e.frames));
    endtask

    initial begin
        rst = 1'b1;
        AN = '1;
        SEGMENT = '1;
        m_frames = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("reset.hex",    32'(hex),    32'h0);
        check_eq("reset.points", 32'(points), 32'h0);
        check_eq("reset.blank",  32'(blank),  32'h0);
        check_eq("reset.err",    32'(err),    32'h0);
        check_eq("reset.frame",  32'(frame),  32'h0);
        rst = 1'b0;

        // First sample appears exactly SETTLE+1 edges after driving.
        apply(4'b1110, 8'hC0, SETTLE + 1, 1'b1, "d0_zero");

        // Scan 1,2,3,4; digit 0 checked one edge before its sample lands.
        apply(4'b1110, 8'hF9, SETTLE,     1'b0, "d0_early");
        apply(4'b1110, 8'hF9, 2,          1'b1, "d0_one");
        apply(4'b1101, 8'hA4, 6,          1'b1, "d1_two");
        apply(4'b1011, 8'h30, 6,          1'b1, "d2_three");
        apply(4'b0111, 8'h99, 6,          1'b1, "d3_four");

        for (int i = 0; i < 10; i++)
            apply(4'b1101, (i % 2 == 0) ? 8'h86 : 8'h80, 2, 1'b0, "glitch");

        apply(4'b0011, 8'hA4, 20, 1'b0, "two_sel");
        apply(4'b1101, 8'hFF, 6,  1'b1, "d1_blank");
        apply(4'b0111, 8'hD5, 6,  1'b1, "d3_bad");
        apply(4'b0111, 8'h8E, 6,  1'b1, "d3_F");

        apply(4'b1110, 8'hC0, 3,  1'b0, "mid_settle");
        rst = 1'b1;
        #1;
        check_eq("rst_mid.hex",    32'(hex),    32'h0);
        check_eq("rst_mid.points", 32'(points), 32'h0);
        check_eq("rst_mid.blank",  32'(blank),  32'h0);
        check_eq("rst_mid.err",    32'(err),    32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_mid.frames", 32'(frame_cnt), 32'(m_frames));
        rst = 1'b0;
        model_reset();

        // Partial mask must be gone: only digit 3 may complete the frame.
        apply(4'b1110, 8'hC0, 6, 1'b1, "post_d0");
        apply(4'b1101, 8'hF9, 6, 1'b1, "post_d1");
        apply(4'b1011, 8'hA4, 6, 1'b1, "post_d2");
        apply(4'b0111, 8'hB0, 6, 1'b1, "post_d3");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_capture.md
SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

Interface
REQ-001 SETTLE, default 4, range 2..255: consecutive stable cycles required before a scanned digit is sampled.
REQ-002 clk  input  1  system clock; all state on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 AN  input  4  digit anodes, active-low; AN[i]=0 selects digit i.
REQ-005 SEGMENT  input  8  segment lines, active-low, order {p,g,f,e,d,c,b,a}.
REQ-006 hex  output  16  recovered digits; hex[4i+3:4i] belongs to digit i.
REQ-007 points  output  4  decimal point of digit i, active-high.
REQ-008 blank  output  4  digit i last seen with all of a..g off.
REQ-009 err  output  4  digit i last seen with an unrecognised a..g pattern.
REQ-010 frame  output  1  one-cycle pulse when all four digits have been captured since the last pulse.

Function
REQ-011 AN and SEGMENT SHALL pass through one input register stage; all following rules act on the registered values.
REQ-012 Legal select: exactly one AN bit low; any other AN value SHALL be treated as no selection.
REQ-013 FSM states: IDLE (no legal select), SETTLE (counting), HELD (sample taken, waiting for change).
REQ-014 IDLE->SETTLE when a legal select appears, with the counter set to 1.
REQ-015 In SETTLE, the counter SHALL increment each cycle that registered AN and SEGMENT equal their previous-cycle values; any change restarts it at 1 (SETTLE), or gives IDLE if the select is no longer legal.
REQ-016 When the counter reaches SETTLE, the digit SHALL be sampled on that edge and the FSM SHALL go to HELD; with inputs constant from edge k, outputs are visible after edge k+SETTLE.
REQ-017 HELD: any change of registered AN or SEGMENT SHALL go to SETTLE (legal select) or IDLE (no legal select); the same digit is not resampled while unchanged.
REQ-018 a..g lookup for active-low {g..a}: 40=0, 79=1, 24=2, 30=3, 19=4, 12=5, 02=6, 78=7, 00=8, 10=9, 08=A, 03=b, 46=C, 21=d, 06=E, 0E=F (hex).
REQ-019 On sample: matched code -> hex nibble=value, blank=0, err=0; 7F -> nibble unchanged, blank=1, err=0; other code -> nibble unchanged, blank=0, err=1.
REQ-020 points[i] SHALL be set to ~SEGMENT[7] on every sample of digit i, regardless of the a..g result.
REQ-021 A 4-bit capture mask SHALL set bit i on each sample of digit i; resampling a set bit SHALL only overwrite data.
REQ-022 When the mask becomes 1111, frame SHALL pulse high for exactly one cycle and the mask SHALL clear on the same edge; a sample on that edge counts toward the next frame.
REQ-023 Digits outside the selected one SHALL hold their outputs.

Reset
REQ-024 On rst: hex=0000, points=0, blank=0, err=0, frame=0, mask=0, counter=0, input registers=all ones (no selection), FSM=IDLE.
REQ-025 Reset asserted mid-settle or mid-frame SHALL discard any partial capture; after release, capture restarts from IDLE.

Structure
REQ-026 Package seg_pkg SHALL hold the 16 segment code constants, the BLANK code 7F and the FSM state encodings.
REQ-027 Sub-module seg_pattern_decode (combinational: 7-bit pattern -> {match, blank, nibble}) SHALL implement REQ-018/019; there is one instance.

Verification
REQ-028 Reset, then AN=1110, SEGMENT=0x40 held -> after SETTLE(4)+1 edges hex[3:0]=0, points[0]=0, err=0, frame=0.
REQ-029 Scan digits 0..3 with codes 0x79, 0x24, 0x30, 0x19 (p bit 1 on digit 2 only cleared to 0), 6 cycles each -> hex=4321, points=0100, a single frame pulse after the digit-3 sample.
REQ-030 Glitch: AN=1101 with SEGMENT changing every 2 cycles for 20 cycles -> no sample, hex[7:4] unchanged, mask unchanged.
REQ-031 AN=0011 (two digits selected) held 20 cycles -> FSM stays IDLE, no output change; SEGMENT=0x7F on digit 1 -> blank[1]=1, hex[7:4] kept.
REQ-032 SEGMENT=0x55 on digit 3 -> err[3]=1; then 0x0E -> hex[15:12]=F, err[3]=0; assert rst mid-settle -> all outputs 0, no frame pulse.
